// File: rtl/adder_8b_stream_acc.sv
// adder_8b_stream_acc: packet accumulator built on the 8-bit prefix adder
// adder_8b_7l   : 8-bit Kogge-Stone prefix adder, a + b -> sum, cout
// adder_8b_stream_acc ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last operand beat stream
//   clear                             synchronous abort of the current packet
//   out_valid/out_ready               per-packet result handshake
//   out_sum/out_carries/out_beats     packet sum, saturating cout count, beat count
// Optional: define ADDER_8B_SATURATE_EN to clamp the running sum at 8'hFF on overflow.
module adder_8b_7l (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g0, p0, g1, p1, g2, p2, g3;
    // Propagate is padded with ones below the span so lower prefixes pass through unchanged.
    assign g0 = a & b;
    assign p0 = a ^ b;
    assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
    assign p1 = p0 & {p0[6:0], 1'b1};
    assign g2 = g1 | (p1 & {g1[5:0], 2'b0});
    assign p2 = p1 & {p1[5:0], 2'b11};
    assign g3 = g2 | (p2 & {g2[3:0], 4'b0});
    assign sum = p0 ^ {g3[6:0], 1'b0};
    assign cout = g3[7];
endmodule

module adder_8b_stream_acc #(
    parameter int MAX_BEATS = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    input  logic          clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_sum,
    output logic [CW-1:0] out_carries,
    output logic [7:0]    out_beats
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state_q, state_d;
    logic [7:0] acc_q, acc_d, beat_cnt_q, beat_cnt_d;
    logic [7:0] out_sum_q, out_sum_d, out_beats_q, out_beats_d;
    logic [CW-1:0] carry_cnt_q, carry_cnt_d, out_carries_q, out_carries_d;
    logic out_valid_q, out_valid_d;
    logic [7:0] sum, acc_nxt;
    logic [CW-1:0] carry_nxt;
    logic cout, accept, pkt_end;

    adder_8b_7l u_add (.a(acc_q), .b(in_data), .sum(sum), .cout(cout));

    assign in_ready = !out_valid_q | out_ready;
    assign accept = in_valid & in_ready & !clear;
    assign pkt_end = accept & (in_last | (beat_cnt_q == 8'(MAX_BEATS - 1)));
`ifdef ADDER_8B_SATURATE_EN
    assign acc_nxt = (cout | (acc_q == 8'hFF)) ? 8'hFF : sum;
`else
    assign acc_nxt = sum;
`endif
    assign carry_nxt = (cout && carry_cnt_q != '1) ? carry_cnt_q + CW'(1) : carry_cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        carry_cnt_d = carry_cnt_q;
        beat_cnt_d = beat_cnt_q;
        out_sum_d = out_sum_q;
        out_carries_d = out_carries_q;
        out_beats_d = out_beats_q;
        // A consumed result drops valid unless a new packet end reloads it below.
        out_valid_d = out_valid_q & !out_ready;
        if (clear) begin
            state_d = IDLE;
            acc_d = '0;
            carry_cnt_d = '0;
            beat_cnt_d = '0;
        end else if (pkt_end) begin
            state_d = IDLE;
            acc_d = '0;
            carry_cnt_d = '0;
            beat_cnt_d = '0;
            out_sum_d = acc_nxt;
            out_carries_d = carry_nxt;
            out_beats_d = beat_cnt_q + 8'd1;
            out_valid_d = 1'b1;
        end else if (accept) begin
            state_d = ACCUM;
            acc_d = acc_nxt;
            carry_cnt_d = carry_nxt;
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            carry_cnt_q <= '0;
            beat_cnt_q <= '0;
            out_sum_q <= '0;
            out_carries_q <= '0;
            out_beats_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            carry_cnt_q <= carry_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            out_sum_q <= out_sum_d;
            out_carries_q <= out_carries_d;
            out_beats_q <= out_beats_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum = out_sum_q;
    assign out_carries = out_carries_q;
    assign out_beats = out_beats_q;
endmodule
